level_sweep_ctrl: RTL and testbench

LEVEL_SWEEP_CTRL -- requirements
Module: level_sweep_ctrl

---
 rtl/sweep_pkg.sv | 33 +++
 rtl/level_updown_counter.sv | 31 +++
 rtl/level_sweep_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_level_sweep_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sweep_pkg                                                       |
// | Purpose  : Shared types and widths for the level sweep controller.         |
// |            The dwell states exist only when SWEEP_DWELL_EN is defined.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package sweep_pkg;

  localparam int                 LEVEL_W   = 3;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;
  localparam int                 PRESC_W   = 8;

`ifdef SWEEP_DWELL_EN
  localparam int DWELL_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_UP        = 3'd1,
    ST_DOWN      = 3'd2,
    ST_DWELL_TOP = 3'd3,
    ST_DWELL_BOT = 3'd4
  } sweep_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } sweep_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/level_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : level_updown_counter                                            |
// | Purpose  : Saturating 0..LEVEL_MAX up/down counter holding the sweep level.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module level_updown_counter
  import sweep_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               down,
  output logic [LEVEL_W-1:0] count
);

  // Saturation guards the ends even if the controller ever misbehaves.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      if (down) begin
        if (count != '0) count <= count - 1'b1;
      end else begin
        if (count != LEVEL_MAX) count <= count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/level_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : level_sweep_ctrl                                                |
// | Purpose  : Frame-paced 0->7->0 level sweep with start/stop control.        |
// |            Define SWEEP_DWELL_EN to hold the end levels for DWELL_STEPS.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module level_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int TICKS_PER_STEP = 4,
  parameter int DWELL_STEPS    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               frameTick,
  output logic [LEVEL_W-1:0] level,
  output logic               dirDown,
  output logic               stepStrobe,
  output logic               sweepDone,
  output logic               busy
);

  generate
    if (TICKS_PER_STEP < 1 || TICKS_PER_STEP > 255 ||
        DWELL_STEPS < 1 || DWELL_STEPS > 15) begin : g_bad_param
      $error("level_sweep_ctrl: TICKS_PER_STEP or DWELL_STEPS out of range");
    end
  endgenerate

  localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(TICKS_PER_STEP - 1);

  sweep_state_t       r_state;
  sweep_state_t       w_state_nxt;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] w_presc_nxt;
  logic               r_stop_pend;
  logic               r_strobe;
  logic               r_done;
  logic               w_strobe_nxt;
  logic               w_done_nxt;
  logic               w_cnt_en;
  logic               w_cnt_down;
  logic               w_step;

`ifdef SWEEP_DWELL_EN
  localparam logic [DWELL_W-1:0] c_dwell_last = DWELL_W'(DWELL_STEPS - 1);

  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] w_dwell_nxt;
`endif

  assign busy       = (r_state != ST_IDLE);
  assign w_step     = busy && frameTick && (r_presc == c_presc_last);
  assign w_cnt_down = (r_state == ST_DOWN);
  assign stepStrobe = r_strobe;
  assign sweepDone  = r_done;

`ifdef SWEEP_DWELL_EN
  assign dirDown = (r_state == ST_DOWN) || (r_state == ST_DWELL_TOP);
`else
  assign dirDown = (r_state == ST_DOWN);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_en     = 1'b0;
    w_strobe_nxt = 1'b0;
    w_done_nxt   = 1'b0;
`ifdef SWEEP_DWELL_EN
    w_dwell_nxt  = r_dwell;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) w_state_nxt = ST_UP;
      end
      ST_UP: begin
        if (w_step) begin
          w_cnt_en     = 1'b1;
          w_strobe_nxt = 1'b1;
          if (level == LEVEL_MAX - 3'd1) begin
`ifdef SWEEP_DWELL_EN
            w_state_nxt = ST_DWELL_TOP;
`else
            w_state_nxt = ST_DOWN;
`endif
          end
        end
      end
      ST_DOWN: begin
        if (w_step) begin
          w_cnt_en     = 1'b1;
          w_strobe_nxt = 1'b1;
          if (level == 3'd1) begin
            w_done_nxt = 1'b1;
            if (r_stop_pend) begin
              w_state_nxt = ST_IDLE;
            end else begin
`ifdef SWEEP_DWELL_EN
              w_state_nxt = ST_DWELL_BOT;
`else
              w_state_nxt = ST_UP;
`endif
            end
          end
        end
      end
`ifdef SWEEP_DWELL_EN
      ST_DWELL_TOP: begin
        if (w_step) begin
          if (r_dwell == c_dwell_last) begin
            w_dwell_nxt = '0;
            w_state_nxt = ST_DOWN;
          end else begin
            w_dwell_nxt = r_dwell + 1'b1;
          end
        end
      end
      ST_DWELL_BOT: begin
        // A pending stop leaves the bottom dwell without waiting for a step.
        if (r_stop_pend) begin
          w_dwell_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_step) begin
          if (r_dwell == c_dwell_last) begin
            w_dwell_nxt = '0;
            w_state_nxt = ST_UP;
          end else begin
            w_dwell_nxt = r_dwell + 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_presc_nxt = r_presc;
    if (w_state_nxt == ST_IDLE) begin
      w_presc_nxt = '0;
    end else if (busy && frameTick) begin
      w_presc_nxt = w_step ? '0 : r_presc + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_stop_pend <= 1'b0;
      r_strobe    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_strobe <= w_strobe_nxt;
      r_done   <= w_done_nxt;
      if (w_state_nxt == ST_IDLE) begin
        r_stop_pend <= 1'b0;
      end else if (busy && stop) begin
        r_stop_pend <= 1'b1;
      end
    end
  end

`ifdef SWEEP_DWELL_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dwell <= '0;
    end else begin
      r_dwell <= w_dwell_nxt;
    end
  end
`endif

  level_updown_counter u_level (
    .clock  (clock),
    .reset  (reset),
    .enable (w_cnt_en),
    .down   (w_cnt_down),
    .count  (level)
  );

endmodule
`default_nettype wire

// File: tb/tb_level_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_level_sweep_ctrl                                             |
// | Purpose  : Self-checking bench for level_sweep_ctrl (table, directed and   |
// |            random stimulus against a sweep-position model).               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_level_sweep_ctrl;

  localparam int TPS = 2;
  localparam int DW  = 2;
`ifdef SWEEP_DWELL_EN
  localparam int D = DW;
`else
  localparam int D = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       frameTick = 1'b0;
  logic [2:0] level;
  logic       dirDown;
  logic       stepStrobe;
  logic       sweepDone;
  logic       busy;
  logic [6:0] dut_vec;

  int checks = 0;
  int errors = 0;

  level_sweep_ctrl #(
    .TICKS_PER_STEP (TPS),
    .DWELL_STEPS    (DW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .frameTick  (frameTick),
    .level      (level),
    .dirDown    (dirDown),
    .stepStrobe (stepStrobe),
    .sweepDone  (sweepDone),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // {level[2:0], dirDown, stepStrobe, sweepDone, busy}
  assign dut_vec = {level, dirDown, stepStrobe, sweepDone, busy};

  // One sweep period as a table of positions; position 0 is "just started".
  logic [2:0] seq_level [0:63];
  bit         seq_dir   [0:63];
  bit         seq_strb  [0:63];
  bit         seq_done  [0:63];
  int         P;

  bit m_busy, m_pend, m_strobe, m_done;
  int m_pos, m_ticks;

  function automatic void init_seq();
    int lv;
    P = 14 + 2 * D;
    seq_level[0] = 3'd0; seq_dir[0] = 0; seq_strb[0] = 0; seq_done[0] = 0;
    for (int p = 1; p <= P; p++) begin
      seq_done[p] = 0;
      if (p <= 7) begin
        lv = p; seq_dir[p] = (p == 7); seq_strb[p] = 1;
      end else if (p <= 7 + D) begin
        lv = 7; seq_dir[p] = 1; seq_strb[p] = 0;
      end else if (p <= 14 + D) begin
        lv = 14 + D - p; seq_dir[p] = (lv != 0); seq_strb[p] = 1; seq_done[p] = (lv == 0);
      end else begin
        lv = 0; seq_dir[p] = 0; seq_strb[p] = 0;
      end
      seq_level[p] = 3'(lv);
    end
  endfunction

  function automatic void model_idle();
    m_busy = 0; m_pos = 0; m_ticks = 0; m_pend = 0;
  endfunction

  function automatic void model_reset();
    model_idle();
    m_strobe = 0; m_done = 0;
  endfunction

  function automatic void model_edge(bit st, bit sp, bit ft);
    bit step;
    bit pend_in;
    m_strobe = 0;
    m_done   = 0;
    if (!m_busy) begin
      if (st && !sp) begin
        m_busy = 1; m_pos = 0; m_ticks = 0;
      end
    end else begin
      pend_in = m_pend;
      step    = ft && (m_ticks == TPS - 1);
      if (ft) m_ticks = step ? 0 : m_ticks + 1;
      m_pend = m_pend | sp;
      if (m_pos > 14 + D && pend_in) begin
        model_idle();
      end else if (step) begin
        m_pos    = (m_pos == P) ? 1 : m_pos + 1;
        m_strobe = seq_strb[m_pos];
        m_done   = seq_done[m_pos];
        if (m_done && pend_in) model_idle();
      end
    end
  endfunction

  function automatic logic [6:0] exp_vec();
    if (m_busy) return {seq_level[m_pos], seq_dir[m_pos], m_strobe, m_done, 1'b1};
    return {3'd0, 1'b0, m_strobe, m_done, 1'b0};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(bit st, bit sp, bit ft);
    start = st; stop = sp; frameTick = ft;
    @(posedge clock);
    #1;
    model_edge(st, sp, ft);
    start = 0; stop = 0; frameTick = 0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("reset_async", {25'd0, dut_vec}, {25'd0, exp_vec()});
    @(posedge clock);
    #1 reset = 1'b0;
    check("reset_hold", {25'd0, dut_vec}, 32'd0);
  endtask

  typedef struct {
    bit         st;
    bit         sp;
    bit         ft;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int done_cnt;
    int s;
    int exp_l;
    int exp_d;

    init_seq();
    model_reset();

    tbl[0] = '{1'b1, 1'b1, 1'b0, 7'b000_0_0_0_0};  // start+stop in IDLE
    tbl[1] = '{1'b0, 1'b0, 1'b1, 7'b000_0_0_0_0};  // frameTick in IDLE
    tbl[2] = '{1'b0, 1'b0, 1'b1, 7'b000_0_0_0_0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 7'b000_0_0_0_1};  // start
    tbl[4] = '{1'b0, 1'b0, 1'b1, 7'b000_0_0_0_1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 7'b001_0_1_0_1};  // first step
    tbl[6] = '{1'b0, 1'b0, 1'b0, 7'b001_0_0_0_1};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 7'b001_0_0_0_1};  // start while busy
    tbl[8] = '{1'b0, 1'b0, 1'b1, 7'b010_0_1_0_1};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 7'b010_0_0_0_1};  // stop -> pending

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", {25'd0, dut_vec}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].st, tbl[i].sp, tbl[i].ft);
      check($sformatf("table_row%0d", i), {25'd0, dut_vec}, {25'd0, tbl[i].exp});
      check($sformatf("table_model%0d", i), {25'd0, dut_vec}, {25'd0, exp_vec()});
    end

    // Pending stop: the sweep runs on to the next level 0, then goes idle.
    for (int i = 0; i < 400 && busy; i++) begin
      tick(0, 0, 1);
      check("stop_run_model", {25'd0, dut_vec}, {25'd0, exp_vec()});
    end
    check("stop_idle_vec", {25'd0, dut_vec}, {25'd0, 7'b000_0_1_1_0});
    tick(0, 0, 1);
    check("stop_idle_after", {25'd0, dut_vec}, 32'd0);

`ifndef SWEEP_DWELL_EN
    // Full period with plain arithmetic: level = step count folded at 7.
    done_cnt = 0;
    tick(1, 0, 0);
    for (int t = 1; t <= 28; t++) begin
      tick(0, 0, 1);
      s     = t / TPS;
      exp_l = (s <= 7) ? s : 14 - s;
      exp_d = (s >= 7 && s < 14) ? 1 : 0;
      if (sweepDone) done_cnt++;
      check($sformatf("period_t%0d", t), {28'd0, level, dirDown}, 32'((exp_l << 1) | exp_d));
    end
    check("period_done_count", 32'(done_cnt), 32'd1);
    check("period_busy_up", {30'd0, busy, dirDown}, 32'b10);
`else
    tick(1, 0, 0);
`endif

    // Reset in the middle of the descent.
    for (int i = 0; i < 400 && !(level == 3'd4 && dirDown); i++) tick(0, 0, 1);
    check("reach_l4_down", {28'd0, level, dirDown}, {28'd0, 3'd4, 1'b1});
    do_reset();
    tick(1, 0, 0);
    for (int i = 0; i < TPS - 1; i++) begin
      tick(0, 0, 1);
      check("restart_wait", {25'd0, dut_vec}, {25'd0, 7'b000_0_0_0_1});
    end
    tick(0, 0, 1);
    check("restart_l1", {25'd0, dut_vec}, {25'd0, 7'b001_0_1_0_1});

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        tick($urandom_range(0, 15) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1);
        check("random", {25'd0, dut_vec}, {25'd0, exp_vec()});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
